keccak_squeeze_unit: RTL and testbench
======================================

// Module: keccak_squeeze_unit
// PURPOSE
// - Reader side of the Keccak state array: snapshots a permuted 5x5x64 state and streams its rate lanes out as 64-bit beats.
// - Streams over a valid/ready interface until the requested output length is delivered.
// - Requests another permutation whenever the rate portion is used up before the output length is met (SHAKE squeeze).
// - Sits between the permutation round datapath and the digest/XOF output port of keccak_core.
// PARAMETERS
// - OUT_LEN_W   16   width of the output byte-length request (max 65535 bytes)
// - RATE_IDX_W  5    width of the rate-in-lanes field (legal 1..21)
// PORTS
// - clk             in   1       single clock, all logic on posedge
// - rst_n           in   1       asynchronous active-low reset
// - start_i         in   1       1-cycle pulse; accepted only in IDLE
// - out_len_i       in   OUT_LEN_W  requested output bytes, sampled with start_i
// - rate_lanes_i    in   RATE_IDX_W rate r/64 (SHA3-256=17, SHAKE128=21), sampled with start_i
// - state_array_i   in   [ROW_SIZE][COL_SIZE][LANE_SIZE]  permuted state; first index x, second y
// - perm_req_o      out  1       level: another permutation is needed
// - perm_done_i     in   1       1-cycle pulse: state_array_i holds the new permuted state
// - out_valid_o     out  1       beat valid
// - out_ready_i     in   1       sink ready
// - out_data_o      out  64      lane data; byte k = lane[8k+7:8k] (little-endian)
// - out_keep_o      out  8       byte enables; contiguous from bit 0
// - out_last_o      out  1       final beat of the request
// - busy_o          out  1       high whenever FSM != IDLE
// - done_o          out  1       1-cycle pulse when the request completes
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM=IDLE; lane_idx=0; remaining=0; snapshot=0; all outputs 0.
// - FSM states: IDLE, STREAM, PERM_WAIT.
// - IDLE -> STREAM on start_i with out_len_i!=0:
//   - register snapshot <= state_array_i, remaining <= out_len_i, rate <= clamp(rate_lanes_i), lane_idx <= 0.
//   - out_valid_o rises the next cycle (1-cycle latency).
// - start_i with out_len_i==0: no beats; done_o pulses the next cycle; stay in IDLE.
// - Rate clamp: 0 -> 1, >21 -> 21.
// - Lane order: lane index i = x + 5*y, i = 0..rate-1, per FIPS 202 byte order.
// - STREAM:
//   - out_data_o = snapshot[i mod 5][i / 5].
//   - out_keep_o = 8'hFF if remaining>=8, else (1<<remaining)-1.
//   - out_last_o = (remaining<=8).
// - Handshake:
//   - a beat transfers on out_valid_o & out_ready_i.
//   - while valid & !ready, out_data_o, out_keep_o and out_last_o are held stable and valid is never dropped.
// - After each transfer: remaining -= min(8, remaining); lane_idx++.
//   - remaining==0 -> done_o pulse, valid low, go to IDLE.
//   - else lane_idx==rate -> valid low, perm_req_o=1, go to PERM_WAIT.
// - PERM_WAIT: perm_req_o is held high until perm_done_i.
//   - On perm_done_i: snapshot <= state_array_i, lane_idx <= 0, perm_req_o <= 0, go to STREAM.
//   - Valid returns the next cycle.
// - Ignored inputs: start_i outside IDLE; perm_done_i outside PERM_WAIT.
// - Reset mid-operation: immediate abort to reset values; no done_o, no last beat.
// - Widths: remaining is OUT_LEN_W bits and never underflows (min() guarded); lane_idx is 5 bits.
// CONFIGURATION
// - KECCAK_SQUEEZE_ZEROIZE_EN defined:
//   - on done_o, and on entry to PERM_WAIT, the snapshot register is cleared to 0 in the same cycle.
//   - out_data_o is forced to 0 whenever out_valid_o==0.
// - Not defined: the snapshot keeps its last value; out_data_o is don't-care while invalid.
// STRUCTURE
// - keccak_pkg holds ROW_SIZE, COL_SIZE and LANE_SIZE (existing).
// - keccak_pkg adds: MAX_RATE_LANES=21 and typedef squeeze_state_e {IDLE,STREAM,PERM_WAIT}.
// - One sub-module, keccak_lane_select: combinational 25:1 lane mux from state array + lane index (x+5y).
// TESTING
// - SHA3-256: rate=17, out_len=32, ready=1.
//   - Expect 4 beats, lanes 0..3, keep=FF; last on beat 4.
//   - done_o on the cycle after beat 4; perm_req_o never high.
// - Partial lane: rate=17, out_len=13.
//   - Beat 1 keep=FF, beat 2 keep=1F with last=1; remaining=0 afterwards.
// - SHAKE128 squeeze: rate=21, out_len=200.
//   - 21 beats (168 B), then perm_req_o=1.
//   - perm_done_i after 3 cycles with a new state; 4 beats from the new lanes 0..3, keep=FF, last on the 4th.
// - Backpressure: out_ready_i low for 5 cycles mid-stream.
//   - valid/data/keep/last stable throughout; no beat skipped or duplicated.
// - Edge inputs: out_len=0 -> done_o pulse, no beats.
//   - start_i in STREAM and perm_done_i in STREAM are ignored.
//   - rate_lanes=30 behaves as 21.
// - Reset/zeroize: rst_n low mid-stream -> all outputs 0 immediately, FSM=IDLE.
//   - With KECCAK_SQUEEZE_ZEROIZE_EN: snapshot reads 0 after done_o.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants and types for the state-array reader.
// The squeeze unit and its lane multiplexer both import this package.
package keccak_pkg;

  localparam int ROW_SIZE       = 5;
  localparam int COL_SIZE       = 5;
  localparam int LANE_SIZE      = 64;
  localparam int MAX_RATE_LANES = 21;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PERM_WAIT
  } squeeze_state_e;

  // Byte enables for a beat carrying n bytes (n = 0..8), contiguous from bit 0.
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [8:0] ones;
    ones      = (9'd1 << n) - 9'd1;
    keep_mask = (n >= 4'd8) ? 8'hFF : ones[7:0];
  endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Combinational 25:1 lane multiplexer: picks state[x][y] for lane index x + 5*y.
// Out-of-range indices (25..31) return zero.
module keccak_lane_select
  import keccak_pkg::*;
(
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_i,
  input  logic [4:0]                                       lane_idx_i,
  output logic [LANE_SIZE-1:0]                             lane_o
);

  // NOTE: assigning a default before the loop gives every path a value, so no latch is inferred.
  always_comb begin
    lane_o = '0;
    for (int y = 0; y < COL_SIZE; y++) begin
      for (int x = 0; x < ROW_SIZE; x++) begin
        if (lane_idx_i == 5'(x + 5 * y)) lane_o = state_i[x][y];
      end
    end
  end

endmodule

// File: rtl/keccak_squeeze_unit.sv
// Snapshots a permuted Keccak state and streams its rate lanes as 64-bit valid/ready beats,
// requesting further permutations for long (SHAKE) outputs. Option: KECCAK_SQUEEZE_ZEROIZE_EN.
module keccak_squeeze_unit
  import keccak_pkg::*;
#(
  parameter int OUT_LEN_W  = 16,
  parameter int RATE_IDX_W = 5
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start_i,
  input  logic [OUT_LEN_W-1:0]                             out_len_i,
  input  logic [RATE_IDX_W-1:0]                            rate_lanes_i,
  input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
  output logic                                             perm_req_o,
  input  logic                                             perm_done_i,
  output logic                                             out_valid_o,
  input  logic                                             out_ready_i,
  output logic [63:0]                                      out_data_o,
  output logic [7:0]                                       out_keep_o,
  output logic                                             out_last_o,
  output logic                                             busy_o,
  output logic                                             done_o
);

  squeeze_state_e state_q;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] snapshot_q;
  logic [OUT_LEN_W-1:0] remaining_q;
  logic [4:0]           lane_idx_q;
  logic [4:0]           rate_q;
  logic                 out_valid_q;
  logic                 perm_req_q;
  logic                 done_q;

  logic [OUT_LEN_W-1:0] step;
  logic [OUT_LEN_W-1:0] rem_d;
  logic [4:0]           lane_idx_d;
  logic [4:0]           rate_d;
  logic [3:0]           beat_bytes;
  logic                 xfer;
  logic [LANE_SIZE-1:0] lane_data;

  always_comb begin
    if (rate_lanes_i == '0) begin
      rate_d = 5'd1;
    end else if (rate_lanes_i > RATE_IDX_W'(MAX_RATE_LANES)) begin
      rate_d = 5'(MAX_RATE_LANES);
    end else begin
      rate_d = 5'(rate_lanes_i);
    end
  end

  // The step is bounded by remaining itself, so remaining can never wrap below zero.
  assign step       = (remaining_q >= OUT_LEN_W'(8)) ? OUT_LEN_W'(8) : remaining_q;
  assign rem_d      = remaining_q - step;
  assign beat_bytes = step[3:0];
  assign lane_idx_d = lane_idx_q + 5'd1;
  assign xfer       = out_valid_q & out_ready_i;

  keccak_lane_select u_lane_select (
    .state_i    (snapshot_q),
    .lane_idx_i (lane_idx_q),
    .lane_o     (lane_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: snapshot_q is a flop array, not a RAM, so it is reset and never exposes a stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snapshot_q  <= '0;
      remaining_q <= '0;
      lane_idx_q  <= '0;
      rate_q      <= '0;
      out_valid_q <= 1'b0;
      perm_req_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (out_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              snapshot_q  <= state_array_i;
              remaining_q <= out_len_i;
              rate_q      <= rate_d;
              lane_idx_q  <= '0;
              out_valid_q <= 1'b1;
              state_q     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            remaining_q <= rem_d;
            lane_idx_q  <= lane_idx_d;
            if (rem_d == '0) begin
              done_q      <= 1'b1;
              out_valid_q <= 1'b0;
              state_q     <= IDLE;
`ifdef KECCAK_SQUEEZE_ZEROIZE_EN
              snapshot_q  <= '0;
`endif
            end else if (lane_idx_d == rate_q) begin
              out_valid_q <= 1'b0;
              perm_req_q  <= 1'b1;
              state_q     <= PERM_WAIT;
`ifdef KECCAK_SQUEEZE_ZEROIZE_EN
              snapshot_q  <= '0;
`endif
            end
          end
        end
        PERM_WAIT: begin
          if (perm_done_i) begin
            snapshot_q  <= state_array_i;
            lane_idx_q  <= '0;
            perm_req_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= STREAM;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef KECCAK_SQUEEZE_ZEROIZE_EN
  assign out_data_o = out_valid_q ? lane_data : '0;
`else
  assign out_data_o = lane_data;
`endif

  // Keep and last derive from the remaining count; gating with valid keeps them 0 when idle.
  assign out_keep_o  = out_valid_q ? keep_mask(beat_bytes) : 8'h00;
  assign out_last_o  = out_valid_q & (remaining_q <= OUT_LEN_W'(8));
  assign out_valid_o = out_valid_q;
  assign perm_req_o  = perm_req_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Directed bench for keccak_squeeze_unit: SHA3/SHAKE streaming, partial lanes,
// backpressure, ignored inputs, rate clamp and asynchronous reset.
module tb_keccak_squeeze_unit;
  import keccak_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [15:0] out_len_i;
  logic [4:0]  rate_lanes_i;
  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i;
  logic        perm_req_o;
  logic        perm_done_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_data_o;
  logic [7:0]  out_keep_o;
  logic        out_last_o;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic perm_seen;

  keccak_squeeze_unit #(.OUT_LEN_W(16), .RATE_IDX_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .out_len_i     (out_len_i),
    .rate_lanes_i  (rate_lanes_i),
    .state_array_i (state_array_i),
    .perm_req_o    (perm_req_o),
    .perm_done_i   (perm_done_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_keep_o    (out_keep_o),
    .out_last_o    (out_last_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (perm_req_o) perm_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_val(input logic [31:0] seed, input int i);
    return {seed, 24'hC0FFEE, 8'(i)};
  endfunction

  task automatic set_state(input logic [31:0] seed);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        state_array_i[x][y] = lane_val(seed, x + 5 * y);
  endtask

  // Called at a negedge; returns at the negedge after the start cycle.
  task automatic do_start(input logic [15:0] len, input logic [4:0] rate);
    start_i      = 1'b1;
    out_len_i    = len;
    rate_lanes_i = rate;
    @(negedge clk);
    start_i      = 1'b0;
  endtask

  // Waits (bounded) for a transferring beat, checks it, returns at the negedge after it.
  task automatic expect_beat(input string tag, input logic [63:0] d,
                             input logic [7:0] k, input logic l);
    int t = 0;
    while (!(out_valid_o && out_ready_i) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check({tag, "_timeout"}, {63'b0, out_valid_o}, 64'd1);
    check({tag, "_data"}, out_data_o, d);
    check({tag, "_keep"}, {56'b0, out_keep_o}, {56'b0, k});
    check({tag, "_last"}, {63'b0, out_last_o}, {63'b0, l});
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {63'b0, out_valid_o}, 64'd0);
    check({tag, "_data"},  out_data_o, 64'd0);
    check({tag, "_keep"},  {56'b0, out_keep_o}, 64'd0);
    check({tag, "_last"},  {63'b0, out_last_o}, 64'd0);
    check({tag, "_busy"},  {63'b0, busy_o}, 64'd0);
    check({tag, "_done"},  {63'b0, done_o}, 64'd0);
    check({tag, "_preq"},  {63'b0, perm_req_o}, 64'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start_i      = 1'b0;
    out_len_i    = '0;
    rate_lanes_i = '0;
    perm_done_i  = 1'b0;
    out_ready_i  = 1'b1;
    state_array_i = '0;
    perm_seen    = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // SHA3-256: 32 bytes at rate 17.
    perm_seen = 1'b0;
    set_state(32'h1111_0001);
    do_start(16'd32, 5'd17);
    check("t1_latency_valid", {63'b0, out_valid_o}, 64'd1);
    check("t1_busy", {63'b0, busy_o}, 64'd1);
    for (int i = 0; i < 4; i++)
      expect_beat($sformatf("t1_b%0d", i), lane_val(32'h1111_0001, i), 8'hFF, i == 3);
    check("t1_done", {63'b0, done_o}, 64'd1);
    check("t1_valid_low", {63'b0, out_valid_o}, 64'd0);
    check("t1_no_perm_req", {63'b0, perm_seen}, 64'd0);
`ifdef KECCAK_SQUEEZE_ZEROIZE_EN
    check("t1_zeroize_snapshot", {63'b0, |dut.snapshot_q}, 64'd0);
    check("t1_zeroize_data", out_data_o, 64'd0);
`endif
    @(negedge clk);
    check("t1_done_pulse", {63'b0, done_o}, 64'd0);

    // Partial lane: 13 bytes.
    set_state(32'h2222_0002);
    do_start(16'd13, 5'd17);
    expect_beat("t2_b0", lane_val(32'h2222_0002, 0), 8'hFF, 1'b0);
    expect_beat("t2_b1", lane_val(32'h2222_0002, 1), 8'h1F, 1'b1);
    check("t2_done", {63'b0, done_o}, 64'd1);
    check("t2_remaining", {48'b0, dut.remaining_q}, 64'd0);
    @(negedge clk);

    // SHAKE128: 200 bytes at rate 21, one extra permutation.
    set_state(32'h3333_0003);
    do_start(16'd200, 5'd21);
    for (int i = 0; i < 21; i++)
      expect_beat($sformatf("t3_b%0d", i), lane_val(32'h3333_0003, i), 8'hFF, 1'b0);
    check("t3_perm_req", {63'b0, perm_req_o}, 64'd1);
    check("t3_wait_valid", {63'b0, out_valid_o}, 64'd0);
    check("t3_wait_busy", {63'b0, busy_o}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    check("t3_perm_req_held", {63'b0, perm_req_o}, 64'd1);
    set_state(32'h4444_0004);
    perm_done_i = 1'b1;
    @(negedge clk);
    perm_done_i = 1'b0;
    check("t3_perm_req_clr", {63'b0, perm_req_o}, 64'd0);
    check("t3_valid_back", {63'b0, out_valid_o}, 64'd1);
    for (int i = 0; i < 4; i++)
      expect_beat($sformatf("t3_p%0d", i), lane_val(32'h4444_0004, i), 8'hFF, i == 3);
    check("t3_done", {63'b0, done_o}, 64'd1);
    @(negedge clk);

    // Backpressure with ignored start_i / perm_done_i in STREAM.
    set_state(32'h5555_0005);
    do_start(16'd40, 5'd17);
    expect_beat("t4_b0", lane_val(32'h5555_0005, 0), 8'hFF, 1'b0);
    out_ready_i = 1'b0;
    set_state(32'h9999_0009);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_stall%0d_valid", k), {63'b0, out_valid_o}, 64'd1);
      check($sformatf("t4_stall%0d_data", k), out_data_o, lane_val(32'h5555_0005, 1));
      check($sformatf("t4_stall%0d_keep", k), {56'b0, out_keep_o}, 64'hFF);
      check($sformatf("t4_stall%0d_last", k), {63'b0, out_last_o}, 64'd0);
      start_i     = (k == 1);
      out_len_i   = 16'd8;
      perm_done_i = (k == 3);
      @(negedge clk);
    end
    start_i     = 1'b0;
    perm_done_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 1; i < 5; i++)
      expect_beat($sformatf("t4_b%0d", i), lane_val(32'h5555_0005, i), 8'hFF, i == 4);
    check("t4_done", {63'b0, done_o}, 64'd1);
    @(negedge clk);

    // Zero-length request.
    do_start(16'd0, 5'd17);
    check("t5_done", {63'b0, done_o}, 64'd1);
    check("t5_valid", {63'b0, out_valid_o}, 64'd0);
    check("t5_busy", {63'b0, busy_o}, 64'd0);
    @(negedge clk);
    check("t5_done_pulse", {63'b0, done_o}, 64'd0);
    check("t5_valid2", {63'b0, out_valid_o}, 64'd0);

    // Rate 30 clamps to 21, then reset while waiting for a permutation.
    set_state(32'h6666_0006);
    do_start(16'd200, 5'd30);
    for (int i = 0; i < 21; i++)
      expect_beat($sformatf("t6_b%0d", i), lane_val(32'h6666_0006, i), 8'hFF, 1'b0);
    check("t6_perm_req", {63'b0, perm_req_o}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-stream.
    set_state(32'h7777_0007);
    do_start(16'd64, 5'd17);
    expect_beat("t7_b0", lane_val(32'h7777_0007, 0), 8'hFF, 1'b0);
    expect_beat("t7_b1", lane_val(32'h7777_0007, 1), 8'hFF, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t7_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("t7_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
